// File: rtl/muldiv_pkg.sv
// Shared definitions for the muldiv unit: op encodings, FSM states, iteration count.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int unsigned MD_ITER = 32;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFix  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor
// and keep the difference when it is non-negative.
module muldiv_divstep #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic                  bit_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic                  q_o
);

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    // Low bits of the wrapped difference are exact whenever the subtraction is kept.
    diff    = shifted[DATA_WIDTH-1:0] - divisor_i;
    q_o     = (shifted >= {1'b0, divisor_i});
    rem_o   = q_o ? diff : shifted[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(MD_ITER);
  localparam logic [CntW-1:0] CntLast = CntW'(MD_ITER - 1);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    opb_q, opb_d;
  logic            is_div_q, is_div_d;
  logic            neg_p_q, neg_p_d;
  logic            neg_r_q, neg_r_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  logic            is_signed;
  logic [W-1:0]    mag_a, mag_b;
  logic [W:0]      mul_sum;
  logic [W-1:0]    div_rem;
  logic            div_q;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quot_fix, rem_fix;

  muldiv_divstep #(
    .DATA_WIDTH(W)
  ) u_divstep (
    .rem_i    (acc_q[2*W-1:W]),
    .bit_i    (acc_q[W-1]),
    .divisor_i(opb_q),
    .rem_o    (div_rem),
    .q_o      (div_q)
  );

  always_comb begin
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    mag_a     = (is_signed && a[W-1]) ? -a : a;
    mag_b     = (is_signed && b[W-1]) ? -b : b;
    // Multiplier bits sit in acc low half; partial product accumulates in the high half.
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    prod_fix  = neg_p_q ? -acc_q : acc_q;
    quot_fix  = neg_p_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix   = neg_r_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d    = {{W{1'b0}}, mag_a};
          opb_d    = mag_b;
          is_div_d = op[1];
          neg_p_d  = is_signed && (a[W-1] ^ b[W-1]);
          neg_r_d  = is_signed && a[W-1];
          cnt_d    = '0;
          state_d  = StRun;
`ifdef MULDIV_FAST_MUL_EN
          if (!op[1]) begin
            acc_d   = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
            state_d = StFix;
          end
`endif
        end else begin
          if (hi_we) hi_d = wd;
          if (lo_we) lo_d = wd;
        end
      end
      StRun: begin
        if (is_div_q) begin
          acc_d = {div_rem, acc_q[W-2:0], div_q};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Directed self-checking bench for muldiv; inputs driven and outputs sampled on negedge.
module tb_muldiv;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wd;
  logic        hi_we, lo_we;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int cycles;

  always #5 clk = ~clk;

  muldiv #(
    .DATA_WIDTH(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wd   (wd),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives start for one cycle and returns at the negedge after edge N.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges with busy high; returns at the first negedge with busy low.
  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      total++;
      failed++;
      $error("FAIL timeout: busy still high after %0d cycles", n);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    wd    = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;

    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cycles);
    check("multu_cycles", cycles, MUL_LAT);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(cycles);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(cycles);
    check("div_cycles", cycles, DIV_LAT);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    launch(OP_DIVU, 32'd7, 32'd0);
    wait_done(cycles);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'd7);

    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cycles);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0);

    // Both writes in one cycle share wd, then a lone mtlo.
    hi_we = 1'b1;
    lo_we = 1'b1;
    wd    = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthilo_hi", hi, 32'h0000_1234);
    check("mthilo_lo", lo, 32'h0000_1234);
    lo_we = 1'b1;
    wd    = 32'h0000_5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h0000_5678);
    check("mtlo_hi_kept", hi, 32'h0000_1234);

    // start and mthi during busy are ignored; hi/lo hold until completion.
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = OP_MULTU;
    a     = 32'd9;
    b     = 32'd9;
    hi_we = 1'b1;
    wd    = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    check("busy_hold_hi", hi, 32'h0000_1234);
    check("busy_hold_lo", lo, 32'h0000_5678);
    wait_done(cycles);
    check("busy_ign_lo", lo, 32'd14);
    check("busy_ign_hi", hi, 32'd2);
    @(negedge clk);
    check("busy_ign_nostart", {31'b0, busy}, 32'd0);

    // start with mtlo: the write is dropped.
    lo_we = 1'b1;
    wd    = 32'h0000_9999;
    launch(OP_MULTU, 32'd2, 32'd3);
    lo_we = 1'b0;
    check("start_lowe_drop", lo, 32'd14);
    wait_done(cycles);
    check("start_lowe_lo", lo, 32'd6);
    check("start_lowe_hi", hi, 32'd0);

    // Reset mid-division.
    hi_we = 1'b1;
    wd    = 32'h0000_AAAA;
    @(negedge clk);
    hi_we = 1'b0;
    launch(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    launch(OP_MULTU, 32'd3, 32'd5);
    wait_done(cycles);
    check("mul35_cycles", cycles, MUL_LAT);
    check("mul35_lo", lo, 32'd15);
    check("mul35_hi", hi, 32'd0);

    // Back-to-back: start in the first idle cycle.
    launch(OP_DIVU, 32'd15, 32'd4);
    wait_done(cycles);
    check("b2b_cycles", cycles, DIV_LAT);
    check("b2b_lo", lo, 32'd3);
    check("b2b_hi", hi, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
